// File: rtl/cdr_pkg.sv
// Shared types for the CDR digital loop filter.
// Loop states and the signed per-window decision.
package cdr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK
    } state_t;

    typedef logic signed [1:0] dec_t;

    localparam dec_t DEC_UP   = 2'sb01;
    localparam dec_t DEC_DN   = 2'sb11;
    localparam dec_t DEC_NONE = 2'sb00;

endpackage

// File: rtl/cdr_vote_window.sv
// Majority vote of Up/Dn over a fixed window.
// Emits a signed decision strobed on the window's last vote.
module cdr_vote_window
    import cdr_pkg::*;
#(
    parameter int VOTE_LEN = 8,
    parameter int VOTE_TH  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic up,
    input  logic dn,
    output dec_t dec,
    output logic dec_valid
);

    localparam int SW = $clog2(VOTE_LEN) + 2;
    localparam int CW = (VOTE_LEN > 1) ? $clog2(VOTE_LEN) : 1;
    localparam logic signed [SW-1:0] TH_P = SW'(VOTE_TH);
    localparam logic signed [SW-1:0] TH_N = -TH_P;
    localparam logic signed [SW-1:0] ONE  = SW'(1);

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] sum_next;
    logic [CW-1:0]        cnt;
    logic                 last;

    always_comb begin
        sum_next = sum;
        if (up && !dn) begin
            sum_next = sum + ONE;
        end else if (dn && !up) begin
            sum_next = sum - ONE;
        end
        last      = en && (cnt == CW'(VOTE_LEN - 1));
        dec_valid = last;
        dec       = DEC_NONE;
        if (sum_next >= TH_P) begin
            dec = DEC_UP;
        end else if (sum_next <= TH_N) begin
            dec = DEC_DN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en || last) begin
            sum <= '0;
            cnt <= '0;
        end else begin
            sum <= sum_next;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cdr_digital_loop_filter.sv
// Bang-bang CDR loop filter: PI update of the interpolator code.
// Tracks lock from runs of zero / same-sign window decisions.
module cdr_digital_loop_filter
    import cdr_pkg::*;
#(
    parameter int PI_W       = 7,
    parameter int VOTE_LEN   = 8,
    parameter int VOTE_TH    = 2,
    parameter int KP_ACQ     = 4,
    parameter int KP_TRK     = 1,
    parameter int KI         = 1,
    parameter int INT_W      = 12,
    parameter int KI_SHIFT   = 4,
    parameter int LOCK_WIN   = 16,
    parameter int UNLOCK_WIN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    Up,
    input  logic                    Dn,
    output logic [PI_W-1:0]         pi_code,
    output logic                    code_valid,
    output logic                    locked,
    output logic signed [INT_W-1:0] int_acc
);

    localparam int IMAX = 2 ** (INT_W - 1) - 1;
    localparam int LW   = $clog2(LOCK_WIN + 1);
    localparam int UW   = $clog2(UNLOCK_WIN + 1);

    dec_t dec;
    logic dec_valid;

    state_t                  state, state_next;
    logic [LW-1:0]           lock_cnt, lock_next;
    logic [UW-1:0]           unlock_cnt, unlock_next;
    dec_t                    last_sign, sign_next;
    logic signed [INT_W-1:0] int_next;
    logic [PI_W-1:0]         pi_next;
    int                      s;
    int                      kp;

    cdr_vote_window #(
        .VOTE_LEN (VOTE_LEN),
        .VOTE_TH  (VOTE_TH)
    ) u_vote (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up        (Up),
        .dn        (Dn),
        .dec       (dec),
        .dec_valid (dec_valid)
    );

    always_comb begin
        state_next  = state;
        lock_next   = lock_cnt;
        unlock_next = unlock_cnt;
        sign_next   = last_sign;
        int_next    = int_acc;
        pi_next     = pi_code;
        s           = 0;
        kp          = (state == TRACK) ? KP_TRK : KP_ACQ;
        if (!en) begin
            state_next  = IDLE;
            lock_next   = '0;
            unlock_next = '0;
        end else begin
            if (state == IDLE) begin
                state_next = ACQUIRE;
            end
            if (dec_valid) begin
                // Integrator saturates; the phase code wraps freely.
                s = int'(int_acc) + int'(dec) * KI;
                if (s > IMAX) s = IMAX;
                if (s < -IMAX) s = -IMAX;
                int_next = INT_W'(s);
                pi_next  = pi_code + PI_W'(int'(dec) * kp)
                         + PI_W'(int_next >>> KI_SHIFT);
                if (state == TRACK) begin
                    if (dec == DEC_NONE) begin
                        unlock_next = '0;
                    end else if (unlock_cnt != '0 && dec == last_sign) begin
                        unlock_next = unlock_cnt + 1'b1;
                    end else begin
                        unlock_next = UW'(1);
                    end
                    sign_next = dec;
                    if (unlock_next == UW'(UNLOCK_WIN)) begin
                        state_next  = ACQUIRE;
                        unlock_next = '0;
                    end
                end else begin
                    if (dec == DEC_NONE) begin
                        lock_next = lock_cnt + 1'b1;
                    end else begin
                        lock_next = '0;
                    end
                    if (lock_next == LW'(LOCK_WIN)) begin
                        state_next = TRACK;
                        lock_next  = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lock_cnt   <= '0;
            unlock_cnt <= '0;
            last_sign  <= DEC_NONE;
            int_acc    <= '0;
            pi_code    <= '0;
            code_valid <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_next;
            lock_cnt   <= lock_next;
            unlock_cnt <= unlock_next;
            last_sign  <= sign_next;
            int_acc    <= int_next;
            pi_code    <= pi_next;
            code_valid <= dec_valid;
            locked     <= (state_next == TRACK);
        end
    end

endmodule

// File: tb/tb_cdr_digital_loop_filter.sv
// Directed bench for cdr_digital_loop_filter.
// Expected codes are worked out by hand per window.
module tb_cdr_digital_loop_filter;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              Up;
    logic              Dn;
    logic [6:0]        pi_code;
    logic              code_valid;
    logic              locked;
    logic signed [11:0] int_acc;

    int tests = 0;
    int fails = 0;
    int exp_int;
    int exp_pi;

    cdr_digital_loop_filter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .Up         (Up),
        .Dn         (Dn),
        .pi_code    (pi_code),
        .code_valid (code_valid),
        .locked     (locked),
        .int_acc    (int_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic u, input logic d, input logic e);
        Up = u;
        Dn = d;
        en = e;
        @(posedge clk);
        #1;
    endtask

    // mode 0: Up, 1: Dn, 2: Up&Dn, 3: alternating Up/Dn
    task automatic window(input int mode);
        logic u, d;
        for (int i = 0; i < 8; i++) begin
            case (mode)
                0:       begin u = 1'b1; d = 1'b0; end
                1:       begin u = 1'b0; d = 1'b1; end
                2:       begin u = 1'b1; d = 1'b1; end
                default: begin u = (i % 2 == 0); d = (i % 2 == 1); end
            endcase
            step(u, d, 1'b1);
            if (i < 7) chk("cv_mid", code_valid, 0);
            else       chk("cv_end", code_valid, 1);
        end
    endtask

    task automatic chk_all(input string tag, input int p, input int ia,
                           input int lk);
        chk({tag, "_pi"}, pi_code, p);
        chk({tag, "_int"}, int_acc, ia);
        chk({tag, "_lock"}, locked, lk);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        Up    = 1'b0;
        Dn    = 1'b0;

        for (int i = 0; i < 4; i++) begin
            step(i % 2 == 0, 1'b0, 1'b1);
            chk_all("rst", 0, 0, 0);
            chk("rst_cv", code_valid, 0);
        end
        rst_n = 1'b1;

        window(0);
        chk_all("up1", 4, 1, 0);
        step(1'b1, 1'b1, 1'b1);
        chk("cv_after", code_valid, 0);
        for (int i = 1; i < 8; i++) step(1'b1, 1'b1, 1'b1);
        chk("both_cv", code_valid, 1);
        chk_all("both", 4, 1, 0);
        window(3);
        chk_all("alt", 4, 1, 0);

        for (int w = 0; w < 13; w++) window(3);
        chk_all("prelock", 4, 1, 0);
        window(3);
        chk_all("lock", 4, 1, 1);

        window(1);
        chk_all("trk1", 3, 0, 1);
        window(1);
        chk_all("trk2", 1, -1, 1);
        window(1);
        chk_all("trk3", 127, -2, 1);
        window(1);
        chk_all("unlock", 125, -3, 0);

        window(0);
        chk_all("wrap", 0, -2, 0);
        window(0);
        window(0);
        window(0);
        chk_all("acq4", 11, 1, 0);

        exp_int = 1;
        exp_pi  = 11;
        for (int w = 0; w < 2056; w++) begin
            window(0);
            exp_int = (exp_int + 1 > 2047) ? 2047 : exp_int + 1;
            exp_pi  = (exp_pi + 4 + (exp_int >>> 4)) & 127;
            chk("int_nonneg", int_acc[11], 0);
        end
        chk_all("sat", exp_pi, 2047, 0);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("dis_cv", code_valid, 0);
            chk_all("dis", exp_pi, 2047, 0);
        end
        window(0);
        exp_pi = (exp_pi + 4 + 127) & 127;
        chk_all("reen", exp_pi, 2047, 0);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        chk_all("midrst", 0, 0, 0);
        chk("midrst_cv", code_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
